// File: rtl/fighter_action_ctrl.sv
// fighter_action_ctrl: per-player action sequencer for the rectangle renderer.
// Turns per-frame button levels into mutually exclusive punch/kick/move phases,
// with attack windows followed by cooldown, and tracks the clamped x position.
// Optional stun support is built when FIGHTER_STUN_EN is defined.
module fighter_action_ctrl #(
  parameter int PUNCH_FRAMES    = 8,
  parameter int KICK_FRAMES     = 12,
  parameter int COOLDOWN_FRAMES = 4,
  parameter int STEP            = 4,
  parameter int WIDTH           = 64,
  parameter int X_MAX           = 1024,
  parameter int X_P1            = 100,
  parameter int X_P2            = 800,
  parameter int STUN_FRAMES     = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        player_in,
  input  logic        frame_tick_in,
  input  logic        punch_req_in,
  input  logic        kick_req_in,
  input  logic        fwd_req_in,
  input  logic        back_req_in,
  input  logic        hit_in,
  output logic        punch_out,
  output logic        kick_out,
  output logic        forwards_out,
  output logic        backwards_out,
  output logic [10:0] x_out,
  output logic        busy_out
);

  localparam int CW = 8;
  localparam logic signed [11:0] STEP_S = 12'(STEP);
  localparam logic signed [11:0] XLIM_S = 12'(X_MAX - WIDTH);
  localparam logic [CW-1:0] CD_LOAD = CW'((COOLDOWN_FRAMES == 0) ? 0 : COOLDOWN_FRAMES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE_FWD  = 3'd1,
    MOVE_BACK = 3'd2,
    PUNCH     = 3'd3,
    KICK      = 3'd4,
`ifdef FIGHTER_STUN_EN
    STUN      = 3'd6,
`endif
    COOLDOWN  = 3'd5
  } state_t;

  // Handshake note: there is no valid/ready flow here; frame_tick_in acts as a
  // one-cycle qualifier, and request levels are only meaningful on tick cycles.

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [10:0]     x, x_nxt, x_fwd, x_back;
  logic signed [11:0] x_s, fwd_s, back_s;
  logic            decide, busy_nxt, pend;

  function automatic logic [10:0] clamp(input logic signed [11:0] v);
    if (v < 12'sd0)       return 11'd0;
    else if (v > XLIM_S)  return XLIM_S[10:0];
    else                  return v[10:0];
  endfunction

  // Candidate positions one step forward/backward, saturated to the screen.
  always_comb begin
    x_s    = $signed({1'b0, x});
    fwd_s  = player_in ? (x_s + STEP_S) : (x_s - STEP_S);
    back_s = player_in ? (x_s - STEP_S) : (x_s + STEP_S);
    x_fwd  = clamp(fwd_s);
    x_back = clamp(back_s);
  end

  // Next-state logic; everything holds unless this is a frame tick.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    x_nxt     = x;
    decide    = 1'b0;
    case (state)
      IDLE, MOVE_FWD, MOVE_BACK: decide = 1'b1;
      PUNCH, KICK: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (COOLDOWN_FRAMES == 0) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = COOLDOWN;
          cnt_nxt   = CD_LOAD;
        end
      end
      default: begin
        // Cooldown/stun expiry hands straight to the idle decision so a held
        // button re-engages on the expiry tick without a dead frame.
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
        else           decide  = 1'b1;
      end
    endcase
    if (decide) begin
      cnt_nxt = '0;
      if (punch_req_in) begin
        state_nxt = PUNCH;
        cnt_nxt   = CW'(PUNCH_FRAMES - 1);
      end else if (kick_req_in) begin
        state_nxt = KICK;
        cnt_nxt   = CW'(KICK_FRAMES - 1);
      end else if (fwd_req_in && !back_req_in) begin
        state_nxt = MOVE_FWD;
        x_nxt     = x_fwd;
      end else if (back_req_in && !fwd_req_in) begin
        state_nxt = MOVE_BACK;
        x_nxt     = x_back;
      end else begin
        state_nxt = IDLE;
      end
    end
`ifdef FIGHTER_STUN_EN
    if (pend) begin
      state_nxt = STUN;
      cnt_nxt   = CW'(STUN_FRAMES - 1);
      x_nxt     = x;
    end
`endif
    if (!frame_tick_in) begin
      state_nxt = state;
      cnt_nxt   = cnt;
      x_nxt     = x;
    end
  end

  // Busy covers every state in which requests are locked out.
  always_comb begin
    busy_nxt = (state_nxt == PUNCH) || (state_nxt == KICK) || (state_nxt == COOLDOWN);
`ifdef FIGHTER_STUN_EN
    if (state_nxt == STUN) busy_nxt = 1'b1;
`endif
  end

  // State, counter, position and decoded outputs registered together.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      cnt           <= '0;
      x             <= player_in ? 11'(X_P1) : 11'(X_P2);
      punch_out     <= 1'b0;
      kick_out      <= 1'b0;
      forwards_out  <= 1'b0;
      backwards_out <= 1'b0;
      busy_out      <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      x             <= x_nxt;
      punch_out     <= (state_nxt == PUNCH);
      kick_out      <= (state_nxt == KICK);
      forwards_out  <= (state_nxt == MOVE_FWD);
      backwards_out <= (state_nxt == MOVE_BACK);
      busy_out      <= busy_nxt;
    end
  end

  assign x_out = x;

`ifdef FIGHTER_STUN_EN
  // Sticky hit flag: set by any hit pulse, consumed on the next frame tick.
  always_ff @(posedge clk_in) begin
    if (rst_in)             pend <= 1'b0;
    else if (frame_tick_in) pend <= hit_in;
    else if (hit_in)        pend <= 1'b1;
  end
`else
  logic unused_hit;
  assign pend       = 1'b0;
  assign unused_hit = hit_in ^ pend;
`endif

endmodule

// File: tb/tb_fighter_action_ctrl.sv
// Directed bench for fighter_action_ctrl: a table of per-tick vectors plus
// hand-written multi-tick sequences (attack timing, clamping, reset, hit).
module tb_fighter_action_ctrl;

  logic        clk = 1'b0;
  logic        rst, player, frame_tick, punch_req, kick_req, fwd_req, back_req, hit;
  logic        punch, kick, fwd, back, busy;
  logic [10:0] x;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fighter_action_ctrl dut (
    .clk_in(clk), .rst_in(rst), .player_in(player), .frame_tick_in(frame_tick),
    .punch_req_in(punch_req), .kick_req_in(kick_req), .fwd_req_in(fwd_req),
    .back_req_in(back_req), .hit_in(hit),
    .punch_out(punch), .kick_out(kick), .forwards_out(fwd), .backwards_out(back),
    .x_out(x), .busy_out(busy)
  );

  typedef struct {
    bit p, k, f, b;
    logic [15:0] exp;   // {punch, kick, fwd, back, busy, x[10:0]}
  } vec_t;

  vec_t tbl[20];

  function automatic logic [15:0] pk(input bit ep, ek, ef, eb, ebusy, input int ex);
    return {ep, ek, ef, eb, ebusy, 11'(ex)};
  endfunction

  function automatic vec_t mk(input bit p, k, f, b, input logic [15:0] e);
    vec_t v;
    v.p = p; v.k = k; v.f = f; v.b = b; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] exp);
    logic [15:0] act;
    act = {punch, kick, fwd, back, busy, x};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got p%b k%b f%b b%b busy%b x=%0d, want p%b k%b f%b b%b busy%b x=%0d",
               name, act[15], act[14], act[13], act[12], act[11], act[10:0],
               exp[15], exp[14], exp[13], exp[12], exp[11], exp[10:0]);
    end
  endtask

  // Random request levels between ticks, then one tick with the given levels.
  // Returns on the falling edge after the tick, when outputs are valid.
  task automatic do_tick(input bit p, k, f, b);
    repeat (2) begin
      @(negedge clk);
      punch_req = 1'($urandom_range(0, 1));
      kick_req  = 1'($urandom_range(0, 1));
      fwd_req   = 1'($urandom_range(0, 1));
      back_req  = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    punch_req = p; kick_req = k; fwd_req = f; back_req = b;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic do_reset(input bit p1);
    @(negedge clk);
    player = p1; rst = 1'b1; frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; player = 1'b1; frame_tick = 1'b0; hit = 1'b0;
    punch_req = 1'b0; kick_req = 1'b0; fwd_req = 1'b0; back_req = 1'b0;

    // Vector table from p1 reset (x=100).
    tbl[0]  = mk(0,0,1,0, pk(0,0,1,0,0,104));
    tbl[1]  = mk(0,0,1,0, pk(0,0,1,0,0,108));
    tbl[2]  = mk(0,0,0,1, pk(0,0,0,1,0,104));
    tbl[3]  = mk(0,0,1,1, pk(0,0,0,0,0,104));
    tbl[4]  = mk(0,0,0,0, pk(0,0,0,0,0,104));
    tbl[5]  = mk(1,1,0,0, pk(1,0,0,0,1,104));
    tbl[6]  = mk(0,1,1,0, pk(1,0,0,0,1,104));
    tbl[7]  = mk(0,0,0,1, pk(1,0,0,0,1,104));
    tbl[8]  = mk(1,0,0,0, pk(1,0,0,0,1,104));
    tbl[9]  = mk(0,0,1,0, pk(1,0,0,0,1,104));
    tbl[10] = mk(0,1,0,0, pk(1,0,0,0,1,104));
    tbl[11] = mk(0,0,0,0, pk(1,0,0,0,1,104));
    tbl[12] = mk(0,0,1,0, pk(1,0,0,0,1,104));
    tbl[13] = mk(0,0,1,0, pk(0,0,0,0,1,104));
    tbl[14] = mk(0,1,0,0, pk(0,0,0,0,1,104));
    tbl[15] = mk(1,0,0,0, pk(0,0,0,0,1,104));
    tbl[16] = mk(0,0,1,0, pk(0,0,0,0,1,104));
    tbl[17] = mk(0,1,0,0, pk(0,1,0,0,1,104));
    tbl[18] = mk(1,0,0,0, pk(0,1,0,0,1,104));
    tbl[19] = mk(0,0,0,0, pk(0,1,0,0,1,104));

    // Reset values for both players.
    do_reset(1'b0);
    chk("reset_p2", pk(0,0,0,0,0,800));
    do_reset(1'b1);
    chk("reset_p1", pk(0,0,0,0,0,100));

    for (int i = 0; i < 20; i++) begin
      do_tick(tbl[i].p, tbl[i].k, tbl[i].f, tbl[i].b);
      chk($sformatf("tbl_%0d", i), tbl[i].exp);
    end

    // Punch held 20 ticks: 8 punch, 4 cooldown, punch again from tick 13.
    do_reset(1'b1);
    for (int t = 1; t <= 20; t++) begin
      do_tick(1, 0, 0, 0);
      if (t <= 8 || t >= 13) chk($sformatf("punch_hold_%0d", t), pk(1,0,0,0,1,100));
      else                   chk($sformatf("punch_hold_%0d", t), pk(0,0,0,0,1,100));
    end

    // p2 moving forward, then interrupted by a punch.
    do_reset(1'b0);
    for (int t = 1; t <= 3; t++) begin
      do_tick(0, 0, 1, 0);
      chk($sformatf("p2_fwd_%0d", t), pk(0,0,1,0,0, 800 - 4 * t));
    end
    do_tick(1, 0, 1, 0);
    chk("p2_punch_interrupt", pk(1,0,0,0,1,788));
    do_tick(0, 0, 1, 0);
    chk("p2_punch_frozen", pk(1,0,0,0,1,788));

    // Reset mid-attack aborts with no cooldown.
    do_reset(1'b1);
    do_tick(1, 0, 0, 0);
    chk("abort_punch_on", pk(1,0,0,0,1,100));
    do_reset(1'b1);
    chk("abort_reset", pk(0,0,0,0,0,100));
    do_tick(0, 0, 0, 0);
    chk("abort_no_cooldown", pk(0,0,0,0,0,100));

    // Kick with a hit pulse between ticks 3 and 4.
    do_reset(1'b1);
    do_tick(0, 1, 0, 0);
    chk("kick_1", pk(0,1,0,0,1,100));
    for (int t = 2; t <= 3; t++) begin
      do_tick(0, 0, 0, 0);
      chk($sformatf("kick_%0d", t), pk(0,1,0,0,1,100));
    end
    @(negedge clk); hit = 1'b1;
    @(negedge clk); hit = 1'b0;
    for (int t = 4; t <= 21; t++) begin
      do_tick(0, 0, 0, 0);
`ifdef FIGHTER_STUN_EN
      if (t <= 19) chk($sformatf("stun_%0d", t), pk(0,0,0,0,1,100));
      else         chk($sformatf("stun_%0d", t), pk(0,0,0,0,0,100));
`else
      if (t <= 12)      chk($sformatf("kick_%0d", t), pk(0,1,0,0,1,100));
      else if (t <= 16) chk($sformatf("kick_cd_%0d", t), pk(0,0,0,0,1,100));
      else              chk($sformatf("kick_idle_%0d", t), pk(0,0,0,0,0,100));
`endif
    end

    // p1 walks into the right edge and saturates at 960.
    do_reset(1'b1);
    for (int t = 1; t <= 217; t++) begin
      int ex;
      ex = (100 + 4 * t > 960) ? 960 : 100 + 4 * t;
      do_tick(0, 0, 1, 0);
      chk($sformatf("clamp_hi_%0d", t), pk(0,0,1,0,0,ex));
    end

    // p2 walks into the left edge and saturates at 0.
    do_reset(1'b0);
    for (int t = 1; t <= 202; t++) begin
      int ex;
      ex = (800 - 4 * t < 0) ? 0 : 800 - 4 * t;
      do_tick(0, 0, 1, 0);
      chk($sformatf("clamp_lo_%0d", t), pk(0,0,1,0,0,ex));
    end
    do_tick(0, 0, 0, 1);
    chk("p2_back_from_0", pk(0,0,0,1,0,4));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
